// File: rtl/pipe_stat_monitor_if.sv
// Bus bundle between the CPU-side probe points and the pipeline statistics monitor.
// Master drives the hazard/branch/PC taps and the read select; slave returns the readout.
interface pipe_stat_monitor_if #(
   parameter int CNT_W = 32
) ();
   logic             start_i;
   logic             stall_i;
   logic             jump_i;
   logic             branch_i;
   logic             eq_i;
   logic [31:0]      pc_i;
   logic [1:0]       sel_i;
   logic [CNT_W-1:0] rdata_o;
   logic             done_o;
   logic             hang_o;
   logic [1:0]       state_o;

   modport master (
      output start_i, stall_i, jump_i, branch_i, eq_i, pc_i, sel_i,
      input  rdata_o, done_o, hang_o, state_o
   );

   modport slave (
      input  start_i, stall_i, jump_i, branch_i, eq_i, pc_i, sel_i,
      output rdata_o, done_o, hang_o, state_o
   );
endinterface

// File: rtl/pipe_stat_monitor.sv
// Pipeline statistics monitor: saturating cycle/stall/flush counters, a PC-hang
// watchdog and a sticky cycle-budget flag, all readable through a select mux.
module pipe_stat_monitor #(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 30,
   parameter int WDOG       = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   pipe_stat_monitor_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int               WD_W    = $clog2(WDOG + 1);
   localparam int               SW      = (CNT_W > 5) ? CNT_W : 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_stall;
   logic [CNT_W-1:0] r_flush;
   logic             r_flush_pend;
   logic             r_done;
   logic             r_hang;
   logic [31:0]      r_last_pc;
   logic [WD_W-1:0]  r_wd;

   logic             w_qstall;
   logic             w_redirect;
   logic             w_run_cnt;
   logic             w_run_stop;
   logic             w_budget;
   logic             w_hang_hit;
   logic [CNT_W-1:0] w_cycle_inc;
   logic [63:0]      w_cycle_ext;
   logic [WD_W-1:0]  w_wd_nxt;
   logic [SW-1:0]    w_status;
   logic [CNT_W-1:0] w_rdata;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Stalls raised alongside a jump/branch decode are control hazards, not data stalls.
   assign w_qstall    = bus.stall_i & ~bus.jump_i & ~bus.branch_i;
   assign w_redirect  = bus.jump_i | (bus.branch_i & bus.eq_i);
   assign w_cycle_inc = sat_inc(r_cycle);
   assign w_cycle_ext = 64'(w_cycle_inc);
   assign w_budget    = (w_cycle_ext == 64'(MAX_CYCLES));
   assign w_wd_nxt    = (bus.pc_i != r_last_pc)  ? WD_W'(0) :
                        (r_wd == WD_W'(WDOG))    ? r_wd     : r_wd + WD_W'(1);
   assign w_hang_hit  = ~w_qstall & (w_wd_nxt == WD_W'(WDOG));

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-edge counting strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_run_cnt   = 1'b0;
      w_run_stop  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_i) w_state_nxt = ST_RUN;
            else             w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (!bus.start_i) begin
               w_state_nxt = ST_IDLE;
               w_run_stop  = 1'b1;
            end else begin
               w_run_cnt = 1'b1;
               if (w_budget) w_state_nxt = ST_DONE;
               else          w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Counters, flush pipeline, watchdog and sticky flags.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cycle      <= '0;
         r_stall      <= '0;
         r_flush      <= '0;
         r_flush_pend <= 1'b0;
         r_done       <= 1'b0;
         r_hang       <= 1'b0;
         r_last_pc    <= 32'd0;
         r_wd         <= '0;
      end else if (w_run_cnt) begin
         r_cycle      <= w_cycle_inc;
         if (w_qstall)     r_stall <= sat_inc(r_stall);
         if (r_flush_pend) r_flush <= sat_inc(r_flush);
         r_flush_pend <= w_redirect;
         r_last_pc    <= bus.pc_i;
         if (!w_qstall)    r_wd    <= w_wd_nxt;
         if (w_hang_hit)   r_hang  <= 1'b1;
         if (w_budget)     r_done  <= 1'b1;
      end else if (w_run_stop) begin
         // Leaving RUN still retires a redirect seen on the previous edge.
         if (r_flush_pend) r_flush <= sat_inc(r_flush);
         r_flush_pend <= 1'b0;
      end
   end

   // Read mux over the live registers; unused status bits read as zero.
   always_comb begin
      w_status      = '0;
      w_status[0]   = r_done;
      w_status[1]   = r_hang;
      w_status[3:2] = r_state;
      w_status[4]   = r_flush_pend;
      case (bus.sel_i)
         2'd0:    w_rdata = r_cycle;
         2'd1:    w_rdata = r_stall;
         2'd2:    w_rdata = r_flush;
         2'd3:    w_rdata = w_status[CNT_W-1:0];
         default: w_rdata = '0;
      endcase
   end

   assign bus.rdata_o = w_rdata;
   assign bus.done_o  = r_done;
   assign bus.hang_o  = r_hang;
   assign bus.state_o = r_state;
endmodule

// File: tb/tb_pipe_stat_monitor.sv
// Randomized + directed bench for pipe_stat_monitor against an arithmetic model
// of the statistics rules, with literal pins on the directed scenarios.
`timescale 1ns/100ps
module tb_pipe_stat_monitor;
   localparam int     MAXC = 30;
   localparam int     WD   = 8;
   localparam longint CMAX = 64'hFFFF_FFFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   pipe_stat_monitor_if #(.CNT_W(32)) bus ();
   pipe_stat_monitor_if #(.CNT_W(4))  bus4 ();

   pipe_stat_monitor #(.CNT_W(32), .MAX_CYCLES(MAXC), .WDOG(WD)) dut (
      .clk_i(clk), .rst_i(rst_n), .bus(bus));
   pipe_stat_monitor #(.CNT_W(4), .MAX_CYCLES(MAXC), .WDOG(WD)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .bus(bus4));

   always #10 clk = ~clk;

   // model: state 0 idle / 1 run / 2 done
   int          m_state, m_hang, m_pend, m_wd;
   longint      m_cycle, m_stall, m_flush, m_lastpc;
   logic [63:0] d_rd [4];
   logic        d_done, d_hang;
   logic [1:0]  d_state;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_hang = 0; m_pend = 0; m_wd = 0;
      m_cycle = 0; m_stall = 0; m_flush = 0; m_lastpc = 0;
   endtask

   task automatic model_edge();
      bit qst, red;
      qst = bus.stall_i & !bus.jump_i & !bus.branch_i;
      red = bus.jump_i | (bus.branch_i & bus.eq_i);
      if (m_state == 0) begin
         if (bus.start_i) m_state = 1;
      end else if (m_state == 1) begin
         if (!bus.start_i) begin
            m_flush = sat(m_flush + m_pend);
            m_pend  = 0;
            m_state = 0;
         end else begin
            m_cycle = sat(m_cycle + 1);
            if (qst) m_stall = sat(m_stall + 1);
            m_flush = sat(m_flush + m_pend);
            m_pend  = red;
            if (!qst) begin
               if (longint'(bus.pc_i) == m_lastpc) m_wd = (m_wd + 1 > WD) ? WD : m_wd + 1;
               else                               m_wd = 0;
               if (m_wd == WD) m_hang = 1;
            end
            m_lastpc = longint'(bus.pc_i);
            if (m_cycle == MAXC) m_state = 2;
         end
      end
   endtask

   task automatic check_all(input string tag);
      longint exp [4];
      exp[0] = m_cycle;
      exp[1] = m_stall;
      exp[2] = m_flush;
      exp[3] = ((m_state == 2) ? 1 : 0) + 2 * m_hang + 4 * m_state + 16 * m_pend;
      for (int s = 0; s < 4; s++) begin
         bus.sel_i = 2'(s);
         #1;
         d_rd[s] = 64'(bus.rdata_o);
         chk($sformatf("%s_sel%0d", tag, s), d_rd[s], 64'(exp[s]));
      end
      d_done  = bus.done_o;
      d_hang  = bus.hang_o;
      d_state = bus.state_o;
      chk($sformatf("%s_done", tag), 64'(d_done), 64'((m_state == 2) ? 1 : 0));
      chk($sformatf("%s_hang", tag), 64'(d_hang), 64'(m_hang));
      chk($sformatf("%s_state", tag), 64'(d_state), 64'(m_state));
   endtask

   task automatic drive(input bit st, input bit sl, input bit j, input bit b,
                        input bit e, input logic [31:0] pc);
      bus.start_i = st; bus.stall_i = sl; bus.jump_i = j;
      bus.branch_i = b; bus.eq_i = e; bus.pc_i = pc;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Reset asserted away from any edge, checked while low, released 12 ns later.
   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      chk("lit_rst_state", 64'(d_state), 64'd0);
      chk("lit_rst_cycle", d_rd[0], 64'd0);
      #7;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] pcv;
      bus.sel_i = 2'd0;
      bus4.start_i = 1'b0; bus4.stall_i = 1'b0; bus4.jump_i = 1'b0;
      bus4.branch_i = 1'b0; bus4.eq_i = 1'b0; bus4.pc_i = 32'd0; bus4.sel_i = 2'd0;
      #5;
      do_reset();

      // incrementing PC, no hazards
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step("enter");
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'(4 * i));
         step("run");
      end
      chk("lit_p1_cycle", d_rd[0], 64'd10);
      chk("lit_p1_stall", d_rd[1], 64'd0);
      chk("lit_p1_flush", d_rd[2], 64'd0);
      chk("lit_p1_hang", 64'(d_hang), 64'd0);

      // three data stalls, then a stall masked by a not-taken branch
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd40);
         step("stall");
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd40);
      step("stallbr");
      chk("lit_p2_stall", d_rd[1], 64'd3);
      chk("lit_p2_cycle", d_rd[0], 64'd14);
      chk("lit_p2_flush", d_rd[2], 64'd0);

      // redirect sequence and run to the cycle budget
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step("enter");
      for (int k = 1; k <= 30; k++) begin
         drive(1'b1, 1'b0, k == 5, (k >= 6) && (k <= 8), (k == 6) || (k == 7), 32'(4 * k));
         step("flush");
         if (k == 5) begin
            chk("lit_k5_flush", d_rd[2], 64'd0);
            chk("lit_k5_status", d_rd[3], 64'd20);
         end
         if (k == 6) chk("lit_k6_flush", d_rd[2], 64'd1);
         if (k == 8) chk("lit_k8_flush", d_rd[2], 64'd3);
         if (k == 9) chk("lit_k9_flush", d_rd[2], 64'd3);
         if (k == 29) chk("lit_k29_done", 64'(d_done), 64'd0);
      end
      chk("lit_budget_cycle", d_rd[0], 64'd30);
      chk("lit_budget_done", 64'(d_done), 64'd1);
      chk("lit_budget_state", 64'(d_state), 64'd2);
      for (int i = 0; i < 5; i++) begin
         drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0, 32'($urandom));
         step("frozen");
      end
      chk("lit_frozen_cycle", d_rd[0], 64'd30);
      chk("lit_frozen_stall", d_rd[1], 64'd0);
      chk("lit_frozen_flush", d_rd[2], 64'd3);
      chk("lit_frozen_status", d_rd[3], 64'd9);

      // constant PC hang
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20);
      step("enter");
      for (int k = 1; k <= 9; k++) begin
         step("wd");
         if (k == 7) chk("lit_wd7_hang", 64'(d_hang), 64'd0);
      end
      chk("lit_wd9_hang", 64'(d_hang), 64'd1);

      // alternate stalls: only non-stalled equal-PC cycles accumulate
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20);
      step("enter");
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, (k % 2) == 0, 1'b0, 1'b0, 1'b0, 32'h20);
         step("wdalt");
         if (k == 15) chk("lit_wdalt15_hang", 64'(d_hang), 64'd0);
      end
      chk("lit_wdalt17_hang", 64'(d_hang), 64'd1);

      // asynchronous reset in the middle of a run
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step("enter");
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, k == 2, k == 4, 1'b0, 1'b0, 32'(8 * k));
         step("pre");
      end
      chk("lit_pre_cycle", d_rd[0], 64'd6);
      do_reset();

      // randomized episodes
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         pcv = 32'd0;
         for (int c = 0; c < 70; c++) begin
            case ($urandom_range(0, 3))
               0:       pcv = pcv;
               1:       pcv = $urandom & 32'hFFFF_FFFC;
               default: pcv = pcv + 32'd4;
            endcase
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)), pcv);
            step("rand");
         end
      end

      // narrow counters saturate instead of wrapping
      do_reset();
      bus4.start_i = 1'b1;
      step("n4enter");
      bus4.stall_i = 1'b1;
      for (int i = 0; i < 20; i++) step("n4");
      bus4.sel_i = 2'd1;
      #1;
      chk("lit_n4_stall", 64'(bus4.rdata_o), 64'd15);
      bus4.sel_i = 2'd0;
      #1;
      chk("lit_n4_cycle", 64'(bus4.rdata_o), 64'd15);
      chk("lit_n4_state", 64'(bus4.state_o), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stat_monitor.md
Name: pipe_stat_monitor

Overview:
- Pipeline statistics unit alongside the 5-stage CPU; consumes the CPU's per-cycle hazard, branch and PC signals.
- Keeps cycle, stall and flush counts plus a PC-hang watchdog.
- Raises done after a programmable cycle budget.
- Lets the bench and a future debug port read the statistics from hardware instead of probing hierarchy.

Parameters:
- CNT_W, 32, width of every counter and of rdata_o.
- MAX_CYCLES, 30, cycle budget; done_o asserts when cycle_cnt reaches this value.
- WDOG, 8, consecutive non-stalled cycles with unchanged PC that flag a hang.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  CPU start; counting enabled only while high.
- stall_i  in  1  hazard-unit PC/IF-ID hold request.
- jump_i  in  1  control-unit jump decode (ID stage).
- branch_i  in  1  control-unit branch decode (ID stage).
- eq_i  in  1  ID-stage register-equality result.
- pc_i  in  32  current PC register output.
- sel_i  in  2  read select: 0 cycle, 1 stall, 2 flush, 3 status.
- rdata_o  out  CNT_W  selected counter/status, combinational from registers.
- done_o  out  1  cycle budget reached (sticky).
- hang_o  out  1  watchdog fired (sticky).
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 DONE.

Behaviour:
- Reset (rst_i=0, asynchronous, immediate):
  - All counters and the flush_pend flag go to 0.
  - last_pc and the watchdog counter go to 0.
  - State goes to IDLE; done_o=0, hang_o=0, state_o=0.
- FSM:
  - IDLE->RUN when start_i=1 at a posedge. Nothing counts on the transition edge.
  - RUN->IDLE when start_i=0 at a posedge. Counters hold; a pending flush is still applied on that edge.
  - RUN->DONE on the edge where cycle_cnt becomes MAX_CYCLES.
  - DONE is terminal until reset; counters freeze and start_i is ignored.
- Counter updates, each posedge in RUN:
  - cycle_cnt += 1.
  - Qualified stall: stall_i & ~jump_i & ~branch_i. stall_cnt += 1 on the same edge, so it is visible the cycle after the stall.
  - Taken redirect: jump_i | (branch_i & eq_i). It sets flush_pend on this edge; flush_cnt += 1 on the following edge. flush_cnt therefore lags the redirect by 2 cycles.
  - Back-to-back redirects: each one counts; flush_pend is simply re-set. The increment is never lost.
- Saturation: every counter sticks at all-ones and never wraps.
- Watchdog (RUN only):
  - If pc_i == last_pc and the qualified stall is 0, wd_cnt += 1; otherwise wd_cnt = 0.
  - last_pc <= pc_i every RUN edge.
  - hang_o sets on the edge wd_cnt reaches WDOG and is sticky until reset.
  - Stalled cycles neither advance nor clear wd_cnt.
- Readout, sel_i=3 status word:
  - bit0 done, bit1 hang, bits[3:2] state, bit4 flush_pend.
  - Remaining bits 0.
- Reset mid-run: all state clears at once, with no dependency on the clock. Release is followed by IDLE and waits for start_i.

Test Plan:
- Reset low 12 ns, then start_i=1 and PC incrementing by 4 each cycle with no hazards → after 10 RUN edges: cycle=10, stall=0, flush=0, hang_o=0.
- stall_i=1 for 3 cycles with jump_i/branch_i=0, then one cycle with stall_i=1 and branch_i=1 → stall_cnt=3 (the branch-qualified cycle is excluded); wd_cnt is not advanced by the stalled cycles.
- jump_i pulse at RUN cycle 5, then branch_i=eq_i=1 at cycles 6 and 7:
  - flush_cnt=1 two edges after cycle 5; reaches 3 two edges after cycle 7.
  - branch_i=1 with eq_i=0 adds nothing.
- Run 30 cycles with MAX_CYCLES=30 → done_o rises on edge 30, state_o=2; further stalls and jumps leave all counters unchanged; rdata_o with sel_i=0 reads 30.
- PC held constant at 0x20 with stall_i=0 → hang_o=1 after 8 edges. Repeat with stall_i=1 on alternate cycles → hang_o stays 0 until 8 non-stalled equal-PC cycles have accumulated.
- Assert rst_i=0 mid-cycle during RUN with nonzero counts → rdata_o=0 for every sel_i and state_o=0 with no clock edge; CNT_W=4 variant: 20 stalls saturate stall_cnt at 15.
